// File: rtl/seq_detect_ctrl.sv
// Programmable serial-pattern detector: run-time pattern/length, overlap mode,
// saturating match counter and sticky threshold interrupt under start/stop control.
module seq_detect_ctrl #(
    parameter int MAXLEN = 8,
    parameter int CNTW   = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [MAXLEN-1:0] cfg_pattern,
    input  logic [3:0]        cfg_len,
    input  logic              cfg_overlap,
    input  logic [CNTW-1:0]   cfg_thresh,
    output logic              cfg_err,
    input  logic              start,
    input  logic              stop,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              busy,
    output logic              match,
    output logic [CNTW-1:0]   match_cnt,
    output logic              irq,
    input  logic              irq_clr
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    localparam logic [3:0]        LEN_MAX = 4'(MAXLEN);
    localparam logic [MAXLEN-1:0] PAT_RST = MAXLEN'(4'b1010);

    state_t            r_state;
    logic [MAXLEN-1:0] r_hist;
    logic [3:0]        r_fill;
    logic [MAXLEN-1:0] r_pat;
    logic [3:0]        r_len;
    logic              r_ovl;
    logic [CNTW-1:0]   r_thr;
    logic              r_cfg_ready;
    logic              r_cfg_err;
    logic              r_busy;
    logic              r_match;
    logic [CNTW-1:0]   r_cnt;
    logic              r_irq;

    logic [MAXLEN-1:0] w_hist_nxt;
    logic [MAXLEN-1:0] w_mask;
    logic [3:0]        w_fill_inc;
    logic [CNTW-1:0]   w_cnt_inc;
    logic              w_hit;
    logic              w_len_ok;
    logic              w_thr_hit;

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < MAXLEN; i++) begin
            w_mask[i] = (i < 32'(r_len));
        end
    end

    // Hit is judged on the post-shift history and post-increment fill.
    always_comb begin
        w_hist_nxt = {r_hist[MAXLEN-2:0], in_bit};
        w_fill_inc = (r_fill >= LEN_MAX) ? r_fill : r_fill + 4'd1;
        w_hit      = (((w_hist_nxt ^ r_pat) & w_mask) == '0) && (w_fill_inc >= r_len);
        w_cnt_inc  = (&r_cnt) ? r_cnt : r_cnt + CNTW'(1);
        w_thr_hit  = (r_thr != '0) && (w_cnt_inc == r_thr);
        w_len_ok   = (cfg_len != 4'd0) && (cfg_len <= LEN_MAX);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_hist      <= '0;
            r_fill      <= '0;
            r_pat       <= PAT_RST;
            r_len       <= 4'd4;
            r_ovl       <= 1'b0;
            r_thr       <= '0;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_match     <= 1'b0;
            r_cnt       <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_match   <= 1'b0;
            r_cfg_err <= 1'b0;
            if (irq_clr) r_irq <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        if (w_len_ok) begin
                            r_pat <= cfg_pattern;
                            r_len <= cfg_len;
                            r_ovl <= cfg_overlap;
                            r_thr <= cfg_thresh;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                    if (start) begin
                        r_hist      <= '0;
                        r_fill      <= '0;
                        r_cnt       <= '0;
                        r_state     <= ST_RUN;
                        r_busy      <= 1'b1;
                        r_cfg_ready <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        r_state     <= ST_IDLE;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else if (in_valid) begin
                        r_hist <= w_hist_nxt;
                        r_fill <= (w_hit && !r_ovl) ? 4'd0 : w_fill_inc;
                        if (w_hit) begin
                            r_match <= 1'b1;
                            r_cnt   <= w_cnt_inc;
                            if (w_thr_hit) begin
                                r_irq   <= 1'b1;
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (irq_clr) begin
                        r_state     <= ST_IDLE;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign busy      = r_busy;
    assign match     = r_match;
    assign match_cnt = r_cnt;
    assign irq       = r_irq;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: expected match pulses are queued per beat
// and compared one cycle later; a CNTW=2 instance covers counter saturation.
module tb_seq_detect_ctrl;

    localparam int MAXLEN = 8;
    localparam int CNTW   = 8;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cfg_valid = 1'b0;
    logic [MAXLEN-1:0] cfg_pattern = '0;
    logic [3:0]        cfg_len = '0;
    logic              cfg_overlap = 1'b0;
    logic [CNTW-1:0]   cfg_thresh = '0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_bit = 1'b0;
    logic              irq_clr = 1'b0;

    logic              cfg_ready, cfg_err, busy, match, irq;
    logic [CNTW-1:0]   match_cnt;
    logic              d2_cfg_ready, d2_cfg_err, d2_busy, d2_match, d2_irq;
    logic [1:0]        d2_match_cnt;

    int   checks = 0;
    int   failures = 0;
    logic exp_q[$];
    logic e;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(CNTW)) u_dut (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh),
        .cfg_err(cfg_err), .start(start), .stop(stop),
        .in_valid(in_valid), .in_bit(in_bit), .busy(busy), .match(match),
        .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr)
    );

    seq_detect_ctrl #(.MAXLEN(MAXLEN), .CNTW(2)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .cfg_valid(cfg_valid), .cfg_ready(d2_cfg_ready), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_thresh(cfg_thresh[1:0]),
        .cfg_err(d2_cfg_err), .start(start), .stop(stop),
        .in_valid(in_valid), .in_bit(in_bit), .busy(d2_busy), .match(d2_match),
        .match_cnt(d2_match_cnt), .irq(d2_irq), .irq_clr(irq_clr)
    );

    initial begin
        #200000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1);
    end

    task automatic drive_beat(input logic b, input logic v, input logic exp_m);
        @(negedge clk);
        in_bit   = b;
        in_valid = v;
        exp_q.push_back(exp_m);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] p, input logic [3:0] l, input logic o,
                             input logic [7:0] t, input logic s);
        @(negedge clk);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_thresh = t;
        cfg_valid = 1'b1; start = s;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0; start = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
    endtask

    task automatic do_stop();
        @(negedge clk); stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
    endtask

    task automatic do_irq_clr();
        @(negedge clk); irq_clr = 1'b1;
        @(posedge clk); #1; irq_clr = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL reset_match got=%b exp=0", match); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_match_cnt got=%0d exp=0", match_cnt); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_defaults();
        logic [5:0] bits = 6'b101010;
        logic [5:0] expm = 6'b000100;
        do_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL defaults_busy got=%b exp=1", busy); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL defaults_cfg_ready got=%b exp=0", cfg_ready); end
        for (int i = 0; i < 6; i++) begin
            drive_beat(bits[5-i], 1'b1, expm[5-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL defaults_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL defaults_cnt got=%0d exp=1", match_cnt); end
        do_stop();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL defaults_stop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_overlap();
        logic [5:0] bits = 6'b101010;
        logic [5:0] expm = 6'b000101;
        cfg_write(8'b0000_1010, 4'd4, 1'b1, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            drive_beat(bits[5-i], 1'b1, expm[5-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL overlap_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        checks++; if (match_cnt !== 8'd2) begin failures++; $display("FAIL overlap_cnt got=%0d exp=2", match_cnt); end
        do_stop();
    endtask

    task automatic test_threshold();
        logic [5:0] expm = 6'b011100;
        cfg_write(8'b0000_0011, 4'd2, 1'b1, 8'd3, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            drive_beat(1'b1, 1'b1, expm[5-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL thresh_match beat=%0d got=%b exp=%b", i+1, match, e); end
            if (i == 3) begin
                checks++; if (irq !== 1'b1) begin failures++; $display("FAIL thresh_irq_edge got=%b exp=1", irq); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL thresh_busy_edge got=%b exp=0", busy); end
            end
        end
        checks++; if (match_cnt !== 8'd3) begin failures++; $display("FAIL thresh_cnt_hold got=%0d exp=3", match_cnt); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL thresh_done_ready got=%b exp=0", cfg_ready); end
        do_irq_clr();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL thresh_irq_clr got=%b exp=0", irq); end
        checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL thresh_idle_ready got=%b exp=1", cfg_ready); end
    endtask

    task automatic test_stop_mid();
        logic [8:0] bits = 9'b101001010;
        logic [8:0] expm = 9'b000000001;
        cfg_write(8'b0000_1010, 4'd4, 1'b0, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 3; i++) begin
            drive_beat(bits[8-i], 1'b1, expm[8-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL stop_pre_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        @(negedge clk); stop = 1'b1;
        drive_beat(1'b0, 1'b1, 1'b0);
        stop = 1'b0;
        e = exp_q.pop_front();
        checks++; if (match !== e) begin failures++; $display("FAIL stop_beat_match got=%b exp=%b", match, e); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", busy); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL stop_cnt got=%0d exp=0", match_cnt); end
        do_start();
        for (int i = 3; i < 9; i++) begin
            drive_beat(bits[8-i], 1'b1, expm[8-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL stop_restart_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        do_stop();
    endtask

    task automatic test_invalid_cfg();
        logic [3:0] bits = 4'b1010;
        logic [3:0] expm = 4'b0001;
        cfg_write(8'b0000_0110, 4'd0, 1'b1, 8'd0, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfgerr_len0 got=%b exp=1", cfg_err); end
        @(posedge clk); #1;
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfgerr_pulse_width got=%b exp=0", cfg_err); end
        cfg_write(8'b0000_0110, 4'(MAXLEN + 1), 1'b1, 8'd0, 1'b0);
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfgerr_len_over got=%b exp=1", cfg_err); end
        do_start();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfgerr_clear got=%b exp=0", cfg_err); end
        for (int i = 0; i < 4; i++) begin
            drive_beat(bits[3-i], 1'b1, expm[3-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL cfgerr_old_pat beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        do_stop();
    endtask

    task automatic test_back_to_back();
        logic [3:0] bits = 4'b0110;
        logic [3:0] expm = 4'b0001;
        cfg_write(8'b0000_0110, 4'd4, 1'b0, 8'd0, 1'b1);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL b2b_cfg_err got=%b exp=0", cfg_err); end
        for (int i = 0; i < 4; i++) begin
            drive_beat(bits[3-i], 1'b1, expm[3-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL b2b_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        cfg_write(8'b0000_0000, 4'd0, 1'b0, 8'd0, 1'b0);
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL b2b_run_cfg_ignored got=%b exp=0", cfg_err); end
        do_stop();
    endtask

    task automatic test_gapped();
        logic [3:0] bits = 4'b1010;
        cfg_write(8'b0000_1010, 4'd4, 1'b0, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 4; i++) begin
            drive_beat(bits[3-i], 1'b1, (i == 3));
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL gap_match beat=%0d got=%b exp=%b", i+1, match, e); end
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    drive_beat(1'b1, 1'b0, 1'b0);
                    e = exp_q.pop_front();
                    checks++; if (match !== e) begin failures++; $display("FAIL gap_idle_match beat=%0d gap=%0d got=%b exp=%b", i+1, g, match, e); end
                end
            end
        end
        checks++; if (match_cnt !== 8'd1) begin failures++; $display("FAIL gap_cnt got=%0d exp=1", match_cnt); end
        do_stop();
    endtask

    task automatic test_saturation();
        logic [5:0] expm = 6'b011111;
        cfg_write(8'b0000_0011, 4'd2, 1'b1, 8'd0, 1'b0);
        do_start();
        for (int i = 0; i < 6; i++) begin
            drive_beat(1'b1, 1'b1, expm[5-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL sat_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        checks++; if (match_cnt !== 8'd5) begin failures++; $display("FAIL sat_cnt_w8 got=%0d exp=5", match_cnt); end
        checks++; if (d2_match_cnt !== 2'd3) begin failures++; $display("FAIL sat_cnt_w2 got=%0d exp=3", d2_match_cnt); end
        checks++; if (d2_busy !== 1'b1) begin failures++; $display("FAIL sat_busy_w2 got=%b exp=1", d2_busy); end
        checks++; if (d2_irq !== 1'b0) begin failures++; $display("FAIL sat_irq_w2 got=%b exp=0", d2_irq); end
        do_stop();
    endtask

    task automatic test_async_reset();
        logic [5:0] bits = 6'b101010;
        logic [5:0] expm = 6'b000100;
        do_start();
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b1, 1'b1, (i != 0));
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL arst_pre_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        @(negedge clk); #2; rstn = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy); end
        checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL arst_cnt got=%0d exp=0", match_cnt); end
        checks++; if (match !== 1'b0) begin failures++; $display("FAIL arst_match got=%b exp=0", match); end
        @(negedge clk); rstn = 1'b1;
        do_start();
        for (int i = 0; i < 6; i++) begin
            drive_beat(bits[5-i], 1'b1, expm[5-i]);
            e = exp_q.pop_front();
            checks++; if (match !== e) begin failures++; $display("FAIL arst_default_match beat=%0d got=%b exp=%b", i+1, match, e); end
        end
        do_stop();
    endtask

    initial begin
        #12;
        rstn = 1'b1;
        #1;
        test_reset();
        test_defaults();
        test_overlap();
        test_threshold();
        test_stop_mid();
        test_invalid_cfg();
        test_back_to_back();
        test_gapped();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
